// File: rtl/i2c_pkg.sv
// Shared I2C constants and the bus-arbiter state encoding.
package i2c_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;
    localparam logic [3:0] TMP101_BASE_ADDR = 4'b1001;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;
endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side and i2c_master-side signals of the bus arbiter.
// Optional req_lock is present when I2C_BUS_ARBITER_LOCK_EN is defined.
interface i2c_bus_arbiter_if #(
    parameter int N_REQ = 2
);
    import i2c_pkg::*;

    logic [N_REQ-1:0]            req_ena;
    logic [I2C_ADDR_W*N_REQ-1:0] req_addr;
    logic [N_REQ-1:0]            req_rw;
    logic [I2C_DATA_W*N_REQ-1:0] req_data_wr;
    logic [N_REQ-1:0]            req_busy;
    logic [N_REQ-1:0]            req_ack_error;
    logic [I2C_DATA_W-1:0]       req_data_rd;
    logic [N_REQ-1:0]            grant;
`ifdef I2C_BUS_ARBITER_LOCK_EN
    logic [N_REQ-1:0]            req_lock;
`endif
    logic                        m_ena;
    logic [I2C_ADDR_W-1:0]       m_addr;
    logic                        m_rw;
    logic [I2C_DATA_W-1:0]       m_data_wr;
    logic                        m_busy;
    logic                        m_ack_error;
    logic [I2C_DATA_W-1:0]       m_data_rd;

    // Handshake: a requester raises req_ena and holds it while it wants the bus;
    // the arbiter forwards it as m_ena only while that requester owns grant.
    modport slave (
        input  req_ena, req_addr, req_rw, req_data_wr,
`ifdef I2C_BUS_ARBITER_LOCK_EN
        input  req_lock,
`endif
        input  m_busy, m_ack_error, m_data_rd,
        output req_busy, req_ack_error, req_data_rd, grant,
        output m_ena, m_addr, m_rw, m_data_wr
    );

    modport master (
        output req_ena, req_addr, req_rw, req_data_wr,
`ifdef I2C_BUS_ARBITER_LOCK_EN
        output req_lock,
`endif
        output m_busy, m_ack_error, m_data_rd,
        input  req_busy, req_ack_error, req_data_rd, grant,
        input  m_ena, m_addr, m_rw, m_data_wr
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after i_ptr, with wrap.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 3
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);
    int w_cand;

    // Walk farthest-to-nearest so the nearest candidate after the pointer overwrites last.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_cand   = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = (int'(i_ptr) + k) % N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (i == w_cand && i_req[i]) begin
                    o_onehot    = '0;
                    o_onehot[i] = 1'b1;
                    o_idx       = PTR_W'(i);
                    o_valid     = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_master between N_REQ requesters, grant held per transaction.
// Define I2C_BUS_ARBITER_LOCK_EN to add per-requester req_lock that suppresses release.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    i2c_bus_arbiter_if.slave bus,
    output arb_state_t       o_dbg_state,
    output logic [PTR_W-1:0] o_dbg_rr_ptr,
    output logic             o_dbg_started
);
    arb_state_t       r_state, w_next_state;
    logic [N_REQ-1:0] r_grant, w_next_grant;
    logic [PTR_W-1:0] r_grant_idx, w_next_grant_idx;
    logic [PTR_W-1:0] r_rr_ptr, w_next_rr_ptr;
    logic             r_started, w_next_started;

    logic [N_REQ-1:0] w_pick_onehot;
    logic [PTR_W-1:0] w_pick_idx;
    logic             w_pick_valid;

    logic                  w_m_ena;
    logic [I2C_ADDR_W-1:0] w_m_addr;
    logic                  w_m_rw;
    logic [I2C_DATA_W-1:0] w_m_data_wr;
    logic                  w_own_lock;

    rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr_pick (
        .i_req    (bus.req_ena),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_rr_ptr    <= PTR_W'(N_REQ - 1);
            r_started   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_grant     <= w_next_grant;
            r_grant_idx <= w_next_grant_idx;
            r_rr_ptr    <= w_next_rr_ptr;
            r_started   <= w_next_started;
        end
    end

    // Owner's command is an AND-OR mux on the registered one-hot grant.
    always_comb begin
        w_m_ena     = 1'b0;
        w_m_addr    = '0;
        w_m_rw      = 1'b0;
        w_m_data_wr = '0;
        w_own_lock  = 1'b0;
        if (r_state == ST_OWN) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (r_grant[i]) begin
                    w_m_ena     = bus.req_ena[i];
                    w_m_addr    = bus.req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
                    w_m_rw      = bus.req_rw[i];
                    w_m_data_wr = bus.req_data_wr[i*I2C_DATA_W +: I2C_DATA_W];
`ifdef I2C_BUS_ARBITER_LOCK_EN
                    w_own_lock  = bus.req_lock[i];
`endif
                end
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_grant     = r_grant;
        w_next_grant_idx = r_grant_idx;
        w_next_rr_ptr    = r_rr_ptr;
        w_next_started   = r_started;
        case (r_state)
            ST_IDLE: begin
                if (!bus.m_busy && w_pick_valid) begin
                    w_next_state     = ST_OWN;
                    w_next_grant     = w_pick_onehot;
                    w_next_grant_idx = w_pick_idx;
                    w_next_started   = 1'b0;
                end
            end
            ST_OWN: begin
                if (bus.m_busy) w_next_started = 1'b1;
                // Releasing before the master ever went busy covers an aborted request.
                if (!w_m_ena && !bus.m_busy && !w_own_lock) begin
                    w_next_state   = ST_IDLE;
                    w_next_grant   = '0;
                    w_next_rr_ptr  = r_grant_idx;
                    w_next_started = 1'b0;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign bus.m_ena         = w_m_ena;
    assign bus.m_addr        = w_m_addr;
    assign bus.m_rw          = w_m_rw;
    assign bus.m_data_wr     = w_m_data_wr;
    assign bus.grant         = r_grant;
    assign bus.req_busy      = r_grant & {N_REQ{bus.m_busy}};
    assign bus.req_ack_error = r_grant & {N_REQ{bus.m_ack_error}};
    assign bus.req_data_rd   = bus.m_data_rd;

    assign o_dbg_state   = r_state;
    assign o_dbg_rr_ptr  = r_rr_ptr;
    assign o_dbg_started = r_started;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with two requesters and a hand-driven i2c_master model.
module tb_i2c_bus_arbiter;
    import i2c_pkg::*;

    localparam int N_REQ = 2;
    localparam int PTR_W = 3;

    logic             clk;
    logic             reset_n;
    arb_state_t       dbg_state;
    logic [PTR_W-1:0] dbg_rr_ptr;
    logic             dbg_started;

    int total = 0;
    int bad   = 0;

    i2c_bus_arbiter_if #(.N_REQ(N_REQ)) bus ();

    i2c_bus_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .o_dbg_state   (dbg_state),
        .o_dbg_rr_ptr  (dbg_rr_ptr),
        .o_dbg_started (dbg_started)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        reset_n         = 1'b0;
        bus.req_ena     = '0;
        bus.req_addr    = '0;
        bus.req_rw      = '0;
        bus.req_data_wr = '0;
`ifdef I2C_BUS_ARBITER_LOCK_EN
        bus.req_lock    = '0;
`endif
        bus.m_busy      = 1'b0;
        bus.m_ack_error = 1'b0;
        bus.m_data_rd   = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (bus.grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", bus.grant); end
        total++;
        if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        total++;
        if (dbg_rr_ptr !== 3'd1) begin bad++; $display("FAIL reset_rr_ptr got=%0d exp=1", dbg_rr_ptr); end
        total++;
        if (bus.m_ena !== 1'b0) begin bad++; $display("FAIL reset_m_ena got=%b exp=0", bus.m_ena); end
    endtask

    task automatic test_single();
        apply_reset();
        bus.req_addr[6:0]    = 7'h48;
        bus.req_data_wr[7:0] = 8'h5A;
        bus.req_ena          = 2'b01;
        #1;
        total++;
        if (bus.grant !== 2'b00) begin bad++; $display("FAIL single_grant_early got=%b exp=00", bus.grant); end
        @(negedge clk);
        total++;
        if (bus.grant !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", bus.grant); end
        total++;
        if (bus.m_addr !== 7'h48 || bus.m_ena !== 1'b1 || bus.m_data_wr !== 8'h5A) begin
            bad++; $display("FAIL single_mux got addr=%h ena=%b data=%h exp addr=48 ena=1 data=5a", bus.m_addr, bus.m_ena, bus.m_data_wr);
        end
        bus.m_busy = 1'b1;
        @(negedge clk);
        total++;
        if (bus.req_busy !== 2'b01 || dbg_started !== 1'b1) begin
            bad++; $display("FAIL single_busy got busy=%b started=%b exp busy=01 started=1", bus.req_busy, dbg_started);
        end
        bus.m_busy  = 1'b0;
        bus.req_ena = 2'b00;
        @(negedge clk);
        total++;
        if (bus.grant !== 2'b00 || dbg_rr_ptr !== 3'd0 || bus.m_ena !== 1'b0) begin
            bad++; $display("FAIL single_release got grant=%b ptr=%0d ena=%b exp grant=00 ptr=0 ena=0", bus.grant, dbg_rr_ptr, bus.m_ena);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_order [4];
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
        apply_reset();
        bus.req_ena = 2'b11;
        for (int t = 0; t < 4; t++) begin
            for (int w = 0; w < 8 && bus.grant == 2'b00; w++) @(negedge clk);
            total++;
            if (bus.grant !== exp_order[t]) begin
                bad++; $display("FAIL contention_order[%0d] got=%b exp=%b", t, bus.grant, exp_order[t]);
            end
            bus.m_busy = 1'b1;
            @(negedge clk);
            total++;
            if (bus.req_busy !== exp_order[t]) begin
                bad++; $display("FAIL contention_busy_gate[%0d] got=%b exp=%b", t, bus.req_busy, exp_order[t]);
            end
            bus.m_busy  = 1'b0;
            bus.req_ena = ~exp_order[t];
            @(negedge clk);
            total++;
            if (bus.grant !== 2'b00) begin bad++; $display("FAIL contention_release[%0d] got=%b exp=00", t, bus.grant); end
            bus.req_ena = 2'b11;
        end
        bus.req_ena = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_abort();
        apply_reset();
        bus.req_ena = 2'b10;
        @(negedge clk);
        total++;
        if (bus.grant !== 2'b10 || bus.m_ena !== 1'b1) begin
            bad++; $display("FAIL abort_grant got grant=%b ena=%b exp grant=10 ena=1", bus.grant, bus.m_ena);
        end
        bus.req_ena = 2'b00;
        @(negedge clk);
        total++;
        if (bus.grant !== 2'b00 || bus.m_ena !== 1'b0 || dbg_rr_ptr !== 3'd1) begin
            bad++; $display("FAIL abort_release got grant=%b ena=%b ptr=%0d exp grant=00 ena=0 ptr=1", bus.grant, bus.m_ena, dbg_rr_ptr);
        end
    endtask

    task automatic test_multibyte_and_ack();
        apply_reset();
        bus.req_addr[6:0] = 7'h48;
        bus.req_rw        = 2'b01;
        bus.req_ena       = 2'b01;
        @(negedge clk);
        bus.req_ena = 2'b11;
        bus.m_busy  = 1'b1;
        @(negedge clk);
        bus.m_data_rd = 8'h19;
        bus.m_busy    = 1'b0;
        @(negedge clk);
        total++;
        if (bus.grant !== 2'b01 || bus.req_data_rd !== 8'h19) begin
            bad++; $display("FAIL hold_byte0 got grant=%b rd=%h exp grant=01 rd=19", bus.grant, bus.req_data_rd);
        end
        bus.m_busy = 1'b1;
        @(negedge clk);
        bus.m_data_rd = 8'h80;
        bus.m_busy    = 1'b0;
        @(negedge clk);
        total++;
        if (bus.grant !== 2'b01 || bus.req_data_rd !== 8'h80 || bus.m_rw !== 1'b1) begin
            bad++; $display("FAIL hold_byte1 got grant=%b rd=%h rw=%b exp grant=01 rd=80 rw=1", bus.grant, bus.req_data_rd, bus.m_rw);
        end
        bus.req_ena = 2'b10;
        @(negedge clk);
        total++;
        if (bus.grant !== 2'b00) begin bad++; $display("FAIL hold_release_wins got=%b exp=00", bus.grant); end
        @(negedge clk);
        total++;
        if (bus.grant !== 2'b10) begin bad++; $display("FAIL hold_next_owner got=%b exp=10", bus.grant); end
        bus.m_busy      = 1'b1;
        bus.m_ack_error = 1'b1;
        @(negedge clk);
        total++;
        if (bus.req_ack_error !== 2'b10) begin bad++; $display("FAIL ack_error_gate got=%b exp=10", bus.req_ack_error); end
        total++;
        if (bus.grant !== 2'b10) begin bad++; $display("FAIL ack_error_no_abort got=%b exp=10", bus.grant); end
        bus.m_busy      = 1'b0;
        bus.m_ack_error = 1'b0;
        bus.req_ena     = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.req_ena = 2'b10;
        @(negedge clk);
        bus.m_busy = 1'b1;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.grant !== 2'b00 || bus.m_ena !== 1'b0) begin
            bad++; $display("FAIL async_reset got grant=%b ena=%b exp grant=00 ena=0", bus.grant, bus.m_ena);
        end
        bus.m_busy  = 1'b0;
        bus.req_ena = 2'b11;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.grant !== 2'b01) begin bad++; $display("FAIL async_reset_first got=%b exp=01", bus.grant); end
        bus.req_ena = 2'b00;
        @(negedge clk);
    endtask

`ifdef I2C_BUS_ARBITER_LOCK_EN
    task automatic test_lock();
        apply_reset();
        bus.req_lock = 2'b01;
        bus.req_ena  = 2'b11;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            bus.m_busy = 1'b1;
            @(negedge clk);
            bus.m_busy  = 1'b0;
            bus.req_ena = 2'b10;
            @(negedge clk);
            total++;
            if (bus.grant !== 2'b01) begin bad++; $display("FAIL lock_hold[%0d] got=%b exp=01", t, bus.grant); end
            bus.req_ena = 2'b11;
        end
        bus.req_ena  = 2'b10;
        bus.req_lock = 2'b00;
        @(negedge clk);
        total++;
        if (bus.grant !== 2'b00) begin bad++; $display("FAIL lock_release got=%b exp=00", bus.grant); end
        @(negedge clk);
        total++;
        if (bus.grant !== 2'b10) begin bad++; $display("FAIL lock_next got=%b exp=10", bus.grant); end
        bus.req_ena = 2'b00;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_abort();
        test_multibyte_and_ack();
        test_async_reset();
`ifdef I2C_BUS_ARBITER_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
